seq_divider: RTL
================

Name: seq_divider

Overview:
- Sequential restoring unsigned integer divider for the gate-level ALU.
- Inverse-direction companion of the adder/subtractor datapath: it divides by repeated trial subtraction and restore, one quotient bit per clock.
- Sits beside the combinational add/sub unit; the ALU control starts it with a one-cycle request and collects the result when the done pulse fires.
- Trial subtraction uses the team's ripple add/sub structure in subtract mode, WIDTH+1 bits wide.

Parameters:
- WIDTH, 4, operand width in bits for dividend, divisor, quotient and remainder; legal range 2..32.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_start  input  1  request pulse; sampled only in IDLE or DONE.
- i_dividend  input  WIDTH  unsigned dividend; sampled with i_start.
- i_divisor  input  WIDTH  unsigned divisor; sampled with i_start.
- o_busy  output  1  high while in CALC.
- o_done  output  1  one-cycle pulse when the result is valid.
- o_quotient  output  WIDTH  quotient; stable from o_done until the next accepted start.
- o_remainder  output  WIDTH  remainder; same stability rule as o_quotient.
- o_div_by_zero  output  1  set with o_done if the latched divisor was 0; same stability rule.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset: state=IDLE, step counter=0, internal registers=0. All outputs 0: o_busy, o_done, o_quotient, o_remainder, o_div_by_zero.
- Reset mid-operation: it overrides everything. The next edge goes to IDLE with all outputs 0, and the partial result is discarded.
- State IDLE: o_busy=0, o_done=0.
  - If i_start=1 at the edge: latch dividend into the Q shift register and divisor into register D; clear the WIDTH+1-bit partial remainder R; clear counter; clear o_div_by_zero; go to CALC.
- State CALC, one step per cycle, WIDTH cycles, o_busy=1:
  - Shift {R,Q} left by one; the MSB of Q enters the LSB of R.
  - Compute T = R_shifted - {1'b0,D} with the WIDTH+1-bit subtractor.
  - If no borrow (T MSB = 0): R<=T and new Q LSB=1. Otherwise: R<=R_shifted (restore) and Q LSB=0.
  - Counter increments each step. After step WIDTH-1 the state goes to DONE.
- Outputs at CALC exit: o_quotient<=Q, o_remainder<=R[WIDTH-1:0], o_div_by_zero<=(D==0). They are registered on the CALC->DONE edge.
- State DONE: exactly one cycle, o_done=1, o_busy=0.
  - If i_start=1: accept a new operation exactly as in IDLE and go to CALC (back-to-back). Otherwise go to IDLE.
- Latency: start sampled at edge k; CALC occupies cycles k+1..k+WIDTH; o_done is high in cycle k+WIDTH+1. Fixed at WIDTH+1 cycles for all operands, including divide-by-zero.
- i_start while in CALC is ignored: no restart, no effect on the result.
- Operand inputs are don't-care except at the accepting edge.
- Divide by zero: no special path, the algorithm runs normally. Required result is quotient = all ones (2^WIDTH-1), remainder = dividend, o_div_by_zero=1.
- Arithmetic: unsigned only. Invariants for nonzero divisor: dividend = quotient*divisor + remainder, and remainder < divisor.
- Result outputs hold their value through IDLE; they change only at the next CALC->DONE edge or on reset.

Test Plan:
- WIDTH=4, reset asserted 2 cycles -> every output 0, o_busy=0; then 13/3 with i_start one cycle -> o_busy high 4 cycles, o_done high on cycle 5 after start, q=4, r=1, dbz=0.
- 7/0 -> after 5 cycles q=15, r=7, o_div_by_zero=1; next op 15/1 -> q=15, r=0, dbz cleared to 0.
- 2/5 -> q=0, r=2; then 15/15 -> q=1, r=0; then 0/9 -> q=0, r=0.
- Start 13/3; pulse i_start with 6/2 two cycles later -> ignored; result q=4, r=1 with done still at cycle 5.
- Start 13/3; assert i_rst during the 2nd CALC cycle -> next cycle IDLE, all outputs 0, no o_done pulse; a fresh 9/4 -> q=2, r=1.
- Back-to-back: i_start=1 with 10/3 in the DONE cycle of 13/3 -> first done shows q=4, r=1; second done exactly 5 cycles later shows q=3, r=1; o_busy has no idle gap. Repeat with WIDTH=8, 200/7 -> q=28, r=4.

Source files
------------

// File: rtl/seq_divider.sv
//-----------------------------------------------------------------------------
// Module   : seq_divider
// Purpose  : Sequential restoring unsigned integer divider. Each clock it
//            produces one quotient bit by trial subtraction and restore.
//            A one-cycle start request launches an operation. o_done pulses
//            for one cycle when the result is valid. Latency is a fixed
//            WIDTH+1 cycles, and a zero divisor is included.
// Ports    : i_clk          clock, rising edge
//            i_rst          synchronous active-high reset
//            i_start        request pulse, accepted in IDLE or DONE
//            i_dividend     unsigned dividend, sampled with i_start
//            i_divisor      unsigned divisor, sampled with i_start
//            o_busy         high while the divider is iterating
//            o_done         one-cycle result-valid pulse
//            o_quotient     quotient, held until the next result
//            o_remainder    remainder, held until the next result
//            o_div_by_zero  latched divisor was zero
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module seq_divider #(
   parameter int WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder,
   output logic             o_div_by_zero
);

   localparam int              CNT_W     = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] quo_sr;    // dividend shifts out the top, quotient bits enter the bottom
   logic [WIDTH-1:0] div_reg;
   logic [CNT_W-1:0] step;

   // The partial remainder is conceptually WIDTH+1 bits wide. After every
   // step it is strictly below the divisor, so its top bit is always zero.
   // Only the low WIDTH bits are stored; the full width appears in the
   // shifted value that feeds the subtractor.
   logic [WIDTH-1:0] rem_reg;

   logic [WIDTH:0]   rem_shift;
   logic [WIDTH:0]   sub_b;
   logic [WIDTH:0]   sub_b_eff;
   logic [WIDTH:0]   diff;
   logic [WIDTH:0]   carry;
   logic             sub_mode;
   logic             no_borrow;
   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] quo_next;

   assign rem_shift = {rem_reg, quo_sr[WIDTH-1]};
   assign sub_b     = {1'b0, div_reg};

   // Ripple add/sub structure held permanently in subtract mode. The B
   // operand is inverted and the carry-in is set, giving A + ~B + 1.
   assign sub_mode  = 1'b1;
   assign sub_b_eff = sub_b ^ {(WIDTH+1){sub_mode}};
   assign carry[0]  = sub_mode;

   generate
      for (genvar i = 0; i <= WIDTH; i++) begin : g_bit
         assign diff[i] = rem_shift[i] ^ sub_b_eff[i] ^ carry[i];
         if (i < WIDTH) begin : g_carry
            assign carry[i+1] = (rem_shift[i] & sub_b_eff[i]) |
                                (carry[i] & (rem_shift[i] ^ sub_b_eff[i]));
         end
      end
   endgenerate

   // A clear top bit of the WIDTH+1-bit difference means the trial
   // subtraction did not borrow. In that case the quotient bit is 1.
   assign no_borrow = ~diff[WIDTH];
   assign rem_next  = no_borrow ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
   assign quo_next  = {quo_sr[WIDTH-2:0], no_borrow};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state         <= IDLE;
         step          <= '0;
         quo_sr        <= '0;
         div_reg       <= '0;
         rem_reg       <= '0;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
         o_quotient    <= '0;
         o_remainder   <= '0;
         o_div_by_zero <= 1'b0;
      end else begin
         case (state)
            // DONE accepts a start exactly like IDLE, so a back-to-back
            // request leaves no idle gap in o_busy.
            IDLE, DONE: begin
               o_done <= 1'b0;
               if (i_start) begin
                  quo_sr        <= i_dividend;
                  div_reg       <= i_divisor;
                  rem_reg       <= '0;
                  step          <= '0;
                  o_div_by_zero <= 1'b0;
                  o_busy        <= 1'b1;
                  state         <= CALC;
               end else begin
                  o_busy <= 1'b0;
                  state  <= IDLE;
               end
            end

            CALC: begin
               quo_sr  <= quo_next;
               rem_reg <= rem_next;
               step    <= step + 1'b1;
               if (step == LAST_STEP) begin
                  o_quotient    <= quo_next;
                  o_remainder   <= rem_next;
                  o_div_by_zero <= (div_reg == '0);
                  o_busy        <= 1'b0;
                  o_done        <= 1'b1;
                  state         <= DONE;
               end
            end

            default: begin
               o_busy <= 1'b0;
               o_done <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
